seq_divu: RTL and testbench
===========================

SEQ_DIVU -- requirements
Module: seq_divu

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width.
REQ-002 Parameter: ITER_PER_CYC, default 1, quotient bits resolved per clock; legal values 1, 2, 4.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request pulse from ALU; sampled only in IDLE.
REQ-006 a  input  WIDTH  dividend.
REQ-007 b  input  WIDTH  divisor.
REQ-008 is_signed  input  1  signed request; present only when DIV_SIGNED_EN is defined.
REQ-009 busy  output  1  high from the cycle after start is accepted until done.
REQ-010 done  output  1  one-cycle pulse; hi/lo valid from this cycle.
REQ-011 div0  output  1  registered; set with done when b was 0; held until next done.
REQ-012 hi  output  WIDTH  remainder, registered.
REQ-013 lo  output  WIDTH  quotient, registered.

Function
REQ-014 FSM states: IDLE, CALC, FIX, DONE; encodings come from the shared macro header.
REQ-015 IDLE: when start=1, latch a, b and is_signed, clear the partial remainder and step counter, go to CALC; when start=0, stay in IDLE.
REQ-016 CALC: perform WIDTH/ITER_PER_CYC restoring steps, each step computing shift-left remainder, trial-subtract divisor, set quotient bit if no borrow; go to FIX after the last step.
REQ-017 FIX: apply sign correction (see Configuration), register hi/lo/div0, go to DONE.
REQ-018 DONE: assert done for exactly one cycle, return to IDLE; busy low in DONE.
REQ-019 Latency: start accepted in cycle 0 -> done in cycle WIDTH/ITER_PER_CYC+2 (34 for defaults), independent of operand values.
REQ-020 start while busy or in DONE is ignored; no queuing.
REQ-021 start in the same cycle as done (DONE state) is ignored; earliest new accept is the cycle after done.
REQ-022 Divide by zero: no early exit; natural restoring result required: lo = all ones, hi = a (unsigned); div0=1.
REQ-023 hi/lo/div0 change only on the FIX->DONE edge; they hold between operations.
REQ-024 Operands are captured at accept; changes on a/b while busy have no effect.

Reset
REQ-025 rst low at any time, including mid-CALC: state=IDLE, busy=0, done=0, div0=0, hi=0, lo=0, internal registers cleared; the aborted op produces no done.
REQ-026 First start is accepted in the first clock edge with rst high.

Configuration
REQ-027 Macro DIV_SIGNED_EN: defined -> is_signed port exists; signed requests divide magnitudes, quotient negated if sign(a)!=sign(b), remainder takes sign of a; b=0 signed -> lo = all ones, hi = a; INT_MIN / -1 -> lo = INT_MIN, hi = 0.
REQ-028 Without DIV_SIGNED_EN: no is_signed port, all operations unsigned; FIX still consumes one cycle so latency is identical in both builds.

Structure
REQ-029 FSM state encodings and the div_op select value belong in the shared macro header alongside ALU_SEL_WIDTH; no local redefinitions.
REQ-030 One sub-module, div_step: combinational single restoring step (remainder in, divisor, dividend bit -> remainder out, quotient bit); instantiated ITER_PER_CYC times in a chain.
REQ-031 ALU-side integration: ALU drives start when s==div_op, stalls pipeline on busy, and takes hi/lo from this block.

Verification
REQ-032 Unsigned: a=100, b=7, start pulse -> done at cycle 34, lo=14, hi=2, div0=0, busy high cycles 1-33.
REQ-033 Divide by zero: a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678, div0=1 at done.
REQ-034 Start while busy: second start at cycle 10 with a=9, b=3 -> ignored, exactly one done, result of first op; next op after done returns lo=3, hi=0.
REQ-035 Reset mid-operation: rst low at cycle 15 -> hi=lo=0, busy=0 immediately; no done; next op a=0xFFFFFFFF, b=1 -> lo=0xFFFFFFFF, hi=0.
REQ-036 DIV_SIGNED_EN: a=-7, b=2, is_signed=1 -> lo=-3, hi=-1; a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
REQ-037 Back-to-back: start the cycle after done, 1000 random operands, ITER_PER_CYC in {1,2,4} -> every result matches the a/b, a%b reference model at the expected latency.

Source files
------------

// File: rtl/seq_divu_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | seq_divu_pkg : shared ALU select width, divide op code and FSM encodings     |
// | Revision     : 1.0                                                           |
// +-----------------------------------------------------------------------------+
package seq_divu_pkg;

    localparam int ALU_SEL_WIDTH = 4;
    localparam logic [ALU_SEL_WIDTH-1:0] DIV_OP = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_t;

    function automatic int div_steps(input int width, input int iter_per_cyc);
        return width / iter_per_cyc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_divu_div_step.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | div_step : one combinational restoring-division step                         |
// | Revision : 1.0                                                               |
// +-----------------------------------------------------------------------------+
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] divisor,
    input  logic             dbit,
    output logic [WIDTH-1:0] rem_next,
    output logic             qbit
);

    logic [WIDTH:0] w_shift;

    assign w_shift = {rem, dbit};

    // The compare is WIDTH+1 wide so a zero divisor never borrows and the
    // dividend simply streams into the remainder.
    always_comb begin
        qbit     = (w_shift >= {1'b0, divisor});
        rem_next = qbit ? WIDTH'(w_shift - {1'b0, divisor}) : w_shift[WIDTH-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/seq_divu.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | seq_divu : multi-cycle restoring divider (quotient on lo, remainder on hi)   |
// |            optional signed support via `define DIV_SIGNED_EN                 |
// | Revision : 1.0                                                               |
// +-----------------------------------------------------------------------------+
module seq_divu
    import seq_divu_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int ITER_PER_CYC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef DIV_SIGNED_EN
    input  logic             is_signed,
`endif
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int STEPS = div_steps(WIDTH, ITER_PER_CYC);
    localparam int CNT_W = $clog2(STEPS + 1);

    div_state_t       r_state;
    logic [WIDTH-1:0] r_qd;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_divisor;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_div0;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic [WIDTH-1:0]                   w_a_mag;
    logic [WIDTH-1:0]                   w_b_mag;
    logic [WIDTH-1:0]                   w_hi_fix;
    logic [WIDTH-1:0]                   w_lo_fix;
    logic                               w_div0;
    logic [ITER_PER_CYC:0][WIDTH-1:0]   w_rem;
    logic [ITER_PER_CYC-1:0]            w_qbit;
    logic [WIDTH-1:0]                   w_qd_next;

    assign w_div0 = (r_divisor == '0);

`ifdef DIV_SIGNED_EN
    logic w_neg_a;
    logic w_neg_b;
    logic r_neg_q;
    logic r_neg_r;

    assign w_neg_a = is_signed & a[WIDTH-1];
    assign w_neg_b = is_signed & b[WIDTH-1];
    assign w_a_mag = w_neg_a ? -a : a;
    assign w_b_mag = w_neg_b ? -b : b;

    // Divide-by-zero keeps the raw all-ones quotient; the remainder sign fix
    // alone restores the original dividend.
    assign w_lo_fix = (r_neg_q && !w_div0) ? -r_qd : r_qd;
    assign w_hi_fix = r_neg_r ? -r_rem : r_rem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (r_state == ST_IDLE && start) begin
            r_neg_q <= w_neg_a ^ w_neg_b;
            r_neg_r <= w_neg_a;
        end
    end
`else
    assign w_a_mag  = a;
    assign w_b_mag  = b;
    assign w_lo_fix = r_qd;
    assign w_hi_fix = r_rem;
`endif

    // r_qd shifts dividend bits out of the top while quotient bits enter below.
    assign w_rem[0] = r_rem;

    generate
        for (genvar gi = 0; gi < ITER_PER_CYC; gi++) begin : g_step
            div_step #(
                .WIDTH(WIDTH)
            ) u_div_step (
                .rem      (w_rem[gi]),
                .divisor  (r_divisor),
                .dbit     (r_qd[WIDTH-1-gi]),
                .rem_next (w_rem[gi+1]),
                .qbit     (w_qbit[ITER_PER_CYC-1-gi])
            );
        end
    endgenerate

    assign w_qd_next = {r_qd[WIDTH-1-ITER_PER_CYC:0], w_qbit};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_qd      <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_div0    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_qd      <= w_a_mag;
                        r_divisor <= w_b_mag;
                        r_rem     <= '0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_qd  <= w_qd_next;
                    r_rem <= w_rem[ITER_PER_CYC];
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(STEPS - 1)) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_hi    <= w_hi_fix;
                    r_lo    <= w_lo_fix;
                    r_div0  <= w_div0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign div0 = r_div0;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_seq_divu.sv
`default_nettype none
// Testbench for seq_divu: directed cases with literal expectations plus random
// back-to-back traffic checked every cycle against an arithmetic reference model.
module tb_seq_divu #(
    parameter int ITER = 1
);

    localparam int WIDTH = 32;
    localparam int STEPS = WIDTH / ITER;
`ifdef DIV_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             sgn = 1'b0;
    logic             busy;
    logic             done;
    logic             div0;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_divu #(
        .WIDTH        (WIDTH),
        .ITER_PER_CYC (ITER)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
`ifdef DIV_SIGNED_EN
        .is_signed (sgn),
`endif
        .busy      (busy),
        .done      (done),
        .div0      (div0),
        .hi        (hi),
        .lo        (lo)
    );

    // ---------------- reference model ----------------
    function automatic void ref_div(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                    input logic sg, output logic [WIDTH-1:0] q,
                                    output logic [WIDTH-1:0] r);
        if (bv == '0) begin
            q = '1;
            r = av;
        end else if (sg && SIGNED_BUILD) begin
            if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
                q = av;
                r = '0;
            end else begin
                q = $signed(av) / $signed(bv);
                r = $signed(av) % $signed(bv);
            end
        end else begin
            q = av / bv;
            r = av % bv;
        end
    endfunction

    int               edge_n      = 0;
    int               m_next_free = 0;
    int               m_done_edge = 0;
    int               m_busy_end  = 0;
    bit               m_pending   = 1'b0;
    logic             m_busy      = 1'b0;
    logic             m_done      = 1'b0;
    logic             m_div0      = 1'b0;
    logic [WIDTH-1:0] m_hi        = '0;
    logic [WIDTH-1:0] m_lo        = '0;
    logic [WIDTH-1:0] m_pq        = '0;
    logic [WIDTH-1:0] m_pr        = '0;
    logic             m_pd        = 1'b0;

    // Accepted ops finish STEPS+1 edges later; the next accept is possible only
    // from the cycle after done.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pending   = 1'b0;
            m_busy      = 1'b0;
            m_done      = 1'b0;
            m_div0      = 1'b0;
            m_hi        = '0;
            m_lo        = '0;
            m_next_free = 0;
        end else begin
            edge_n = edge_n + 1;
            m_done = 1'b0;
            if (m_pending && edge_n == m_done_edge) begin
                m_hi      = m_pr;
                m_lo      = m_pq;
                m_div0    = m_pd;
                m_done    = 1'b1;
                m_pending = 1'b0;
            end
            if (!m_pending && start && edge_n >= m_next_free) begin
                ref_div(a, b, sgn, m_pq, m_pr);
                m_pd        = (b == '0);
                m_pending   = 1'b1;
                m_busy_end  = edge_n + STEPS;
                m_done_edge = edge_n + STEPS + 1;
                m_next_free = edge_n + STEPS + 3;
            end
            m_busy = m_pending && (edge_n <= m_busy_end);
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            check("busy_done", {busy, done}, {m_busy, m_done});
            check("div0_hi_lo", {div0, hi, lo}, {m_div0, m_hi, m_lo});
        end
    endtask

    // ---------------- stimulus ----------------
    function automatic logic [WIDTH-1:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return WIDTH'($urandom_range(0, 15));
            2:       return '1;
            3:       return 32'h8000_0000;
            4, 5:    return $urandom >> $urandom_range(0, 31);
            default: return $urandom;
        endcase
    endfunction

    task automatic start_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic sg);
        a     = av;
        b     = bv;
        sgn   = sg;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        sgn   = SIGNED_BUILD ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    task automatic wait_done(output int lat, output bit ok);
        ok  = 1'b0;
        lat = 0;
        for (int i = 1; i <= 4 * STEPS + 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                ok  = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout at %0t: got no done, expected done within %0d cycles",
                     $time, 4 * STEPS + 20);
        end
    endtask

    task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic sg,
                         output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r,
                         output logic d, output int lat);
        bit ok;
        start_op(av, bv, sg);
        wait_done(lat, ok);
        q = lo;
        r = hi;
        d = div0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             d;
        int               lat;
        bit               ok;

        rst = 1'b0;
        fork
            compare_loop();
        join_none
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {busy, done, div0, hi, lo}, '0);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;

        do_op(32'd100, 32'd7, 1'b0, q, r, d, lat);
        check("u100_7_lo", q, 32'd14);
        check("u100_7_hi", r, 32'd2);
        check("u100_7_div0", d, 1'b0);
        check("latency", lat + 1, STEPS + 2);

        do_op(32'h1234_5678, 32'd0, 1'b0, q, r, d, lat);
        check("div0_lo", q, 32'hFFFF_FFFF);
        check("div0_hi", r, 32'h1234_5678);
        check("div0_flag", d, 1'b1);

        // second request while busy must be dropped
        start_op(32'd100, 32'd7, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        a     = 32'd9;
        b     = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, ok);
        check("busy_start_lo", lo, 32'd14);
        check("busy_start_hi", hi, 32'd2);
        @(posedge clk);
        #1;
        do_op(32'd9, 32'd3, 1'b0, q, r, d, lat);
        check("u9_3_lo", q, 32'd3);
        check("u9_3_hi", r, 32'd0);

        // abort mid-calculation
        start_op(32'd1000, 32'd3, 1'b0);
        repeat (14) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_hi_lo", {hi, lo}, '0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        do_op(32'hFFFF_FFFF, 32'd1, 1'b0, q, r, d, lat);
        check("uffff_1_lo", q, 32'hFFFF_FFFF);
        check("uffff_1_hi", r, 32'd0);

`ifdef DIV_SIGNED_EN
        do_op(32'hFFFF_FFF9, 32'd2, 1'b1, q, r, d, lat);
        check("s_m7_2_lo", q, 32'hFFFF_FFFD);
        check("s_m7_2_hi", r, 32'hFFFF_FFFF);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, q, r, d, lat);
        check("s_min_m1_lo", q, 32'h8000_0000);
        check("s_min_m1_hi", r, 32'd0);
        do_op(32'hFFFF_FFFB, 32'd0, 1'b1, q, r, d, lat);
        check("s_div0_lo", q, 32'hFFFF_FFFF);
        check("s_div0_hi", r, 32'hFFFF_FFFB);
`endif

        // back-to-back random traffic; sometimes start is already high in the done cycle
        for (int k = 0; k < 1000; k++) begin
            start_op(rnd_op(), rnd_op(), SIGNED_BUILD ? 1'($urandom_range(0, 1)) : 1'b0);
            wait_done(lat, ok);
            if (!ok) break;
            if ($urandom_range(0, 1) == 1) begin
                start = 1'b1;
                a     = $urandom;
                b     = $urandom;
            end
            @(posedge clk);
            #1;
        end

        repeat (4) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
